// File: rtl/edge_dilate_multi_if.sv
// Control and BRAM port bundle for edge_dilate_multi.
// wr_count exists only when EDGE_DILATE_STATS_EN is defined.
interface edge_dilate_multi_if #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 3
);
  logic              start;
  logic [2:0]        passes;
  logic              conn8;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
`ifdef EDGE_DILATE_STATS_EN
  logic [ADDR_W-1:0] wr_count;
`endif

  // master: sequencer / BRAM side; slave: the dilation engine
  modport master (
    output start, passes, conn8, rd_data,
    input  busy, done, rd_addr, wr_en, wr_addr, wr_data
`ifdef EDGE_DILATE_STATS_EN
    , input wr_count
`endif
  );

  modport slave (
    input  start, passes, conn8, rd_data,
    output busy, done, rd_addr, wr_en, wr_addr, wr_data
`ifdef EDGE_DILATE_STATS_EN
    , output wr_count
`endif
  );
endinterface

// File: rtl/edge_dilate_multi.sv
// In-place multi-pass dilation of the edge-map BRAM: pass p writes p+1 into zero neighbours of interior pixels equal to p.
// Optional EDGE_DILATE_STATS_EN adds a write counter (bus.wr_count).
//
// state     | meaning
// IDLE      | waiting for start
// PRIME     | 9 reads filling the 3x3 window at (1,y)
// CHECK     | test window centre against current pass p
// WRITE     | one neighbour candidate per cycle
// SHIFT     | 3 reads of column x+2, then x++
// NEXT_ROW  | y++, reload window or finish pass
// NEXT_PASS | p++, restart raster or finish
// DONE      | raise done, drop busy
module edge_dilate_multi #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int PIX_W      = 3,
  parameter int ADDR_W     = 19,
  parameter int MAX_PASSES = 6,
  parameter int RD_LAT     = 2
) (
  input  logic               clk,
  input  logic               reset,
  edge_dilate_multi_if.slave bus
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int CW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_CHECK, S_WRITE, S_SHIFT, S_NEXT_ROW, S_NEXT_PASS, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [PIX_W-1:0]  p, pass_lim;
  logic              conn8_q;
  logic [PIX_W-1:0]  win [0:8];
  logic [CW-1:0]     rd_cnt;
  logic [1:0]        rd_r, rd_c;
  logic [2:0]        wr_idx;

  logic              busy_q, done_q, wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [PIX_W-1:0]  wr_data_q;

  logic              x_end, y_end, p_end, rd_hit, rd_last, wr_last;
  logic [2:0]        pass_clamp;
  logic [3:0]        cap_idx;
  logic [ADDR_W-1:0] rd_row, rd_col, rd_addr_c;
  logic [3:0]        cand_win;
  logic [1:0]        cand_dr, cand_dc;
  logic [ADDR_W-1:0] cand_addr;
  logic              cand_zero;

  always_comb begin
    pass_clamp = (bus.passes > 3'(MAX_PASSES)) ? 3'(MAX_PASSES) : bus.passes;
    x_end      = (x == XW'(WIDTH - 2));
    y_end      = (y == YW'(HEIGHT - 2));
    p_end      = (p == pass_lim);
    rd_hit     = (rd_cnt == '0);
    rd_last    = (rd_r == 2'd2) && ((state == S_SHIFT) || (rd_c == 2'd2));
    wr_last    = (wr_idx == (conn8_q ? 3'd7 : 3'd3));
    cap_idx    = (4'(rd_r) * 4'd3) + ((state == S_SHIFT) ? 4'd2 : 4'(rd_c));
    rd_row     = ADDR_W'(y) + ADDR_W'(rd_r) - ADDR_W'(1);
    rd_col     = (state == S_SHIFT) ? (ADDR_W'(x) + ADDR_W'(2))
                                    : (ADDR_W'(x) + ADDR_W'(rd_c) - ADDR_W'(1));
    rd_addr_c  = '0;
    if (state == S_PRIME || state == S_SHIFT)
      rd_addr_c = rd_row * ADDR_W'(WIDTH) + rd_col;
  end

  // Candidate order: up, right, down, left, then the four diagonals.
  always_comb begin
    cand_win = 4'd1;
    cand_dr  = 2'd0;
    cand_dc  = 2'd1;
    unique case (wr_idx)
      3'd0: begin cand_win = 4'd1; cand_dr = 2'd0; cand_dc = 2'd1; end
      3'd1: begin cand_win = 4'd5; cand_dr = 2'd1; cand_dc = 2'd2; end
      3'd2: begin cand_win = 4'd7; cand_dr = 2'd2; cand_dc = 2'd1; end
      3'd3: begin cand_win = 4'd3; cand_dr = 2'd1; cand_dc = 2'd0; end
      3'd4: begin cand_win = 4'd0; cand_dr = 2'd0; cand_dc = 2'd0; end
      3'd5: begin cand_win = 4'd2; cand_dr = 2'd0; cand_dc = 2'd2; end
      3'd6: begin cand_win = 4'd8; cand_dr = 2'd2; cand_dc = 2'd2; end
      default: begin cand_win = 4'd6; cand_dr = 2'd2; cand_dc = 2'd0; end
    endcase
    cand_addr = (ADDR_W'(y) + ADDR_W'(cand_dr) - ADDR_W'(1)) * ADDR_W'(WIDTH)
              + ADDR_W'(x) + ADDR_W'(cand_dc) - ADDR_W'(1);
    cand_zero = (win[cand_win] == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:      if (bus.start) state_nxt = (pass_clamp == 3'd0) ? S_DONE : S_PRIME;
      S_PRIME:     if (rd_hit && rd_last) state_nxt = S_CHECK;
      S_CHECK: begin
        if (win[4] == p) state_nxt = S_WRITE;
        else if (x_end)  state_nxt = S_NEXT_ROW;
        else             state_nxt = S_SHIFT;
      end
      S_WRITE:     if (wr_last) state_nxt = x_end ? S_NEXT_ROW : S_SHIFT;
      S_SHIFT:     if (rd_hit && rd_last) state_nxt = S_CHECK;
      S_NEXT_ROW:  state_nxt = y_end ? S_NEXT_PASS : S_PRIME;
      S_NEXT_PASS: state_nxt = p_end ? S_DONE : S_PRIME;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x         <= '0;
      y         <= '0;
      p         <= '0;
      pass_lim  <= '0;
      conn8_q   <= 1'b0;
      rd_cnt    <= CW'(RD_LAT);
      rd_r      <= '0;
      rd_c      <= '0;
      wr_idx    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      wr_en_q <= 1'b0;
      // Window slides left on entry; the fresh column lands in column 2.
      if (state_nxt == S_SHIFT && state != S_SHIFT) begin
        for (int r = 0; r < 3; r++) begin
          win[r*3]   <= win[r*3+1];
          win[r*3+1] <= win[r*3+2];
        end
      end
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            p        <= PIX_W'(1);
            y        <= YW'(1);
            x        <= XW'(1);
            pass_lim <= PIX_W'(pass_clamp);
            conn8_q  <= bus.conn8;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        S_PRIME, S_SHIFT: begin
          if (rd_hit) begin
            win[cap_idx] <= bus.rd_data;
            rd_cnt       <= CW'(RD_LAT);
            if (rd_last) begin
              rd_r <= '0;
              rd_c <= '0;
              if (state == S_SHIFT) x <= x + XW'(1);
            end else if (state == S_PRIME && rd_c != 2'd2) begin
              rd_c <= rd_c + 2'd1;
            end else begin
              rd_c <= '0;
              rd_r <= rd_r + 2'd1;
            end
          end else begin
            rd_cnt <= rd_cnt - CW'(1);
          end
        end
        S_CHECK: wr_idx <= '0;
        S_WRITE: begin
          wr_en_q   <= cand_zero;
          wr_addr_q <= cand_addr;
          wr_data_q <= p + PIX_W'(1);
          wr_idx    <= wr_idx + 3'd1;
        end
        S_NEXT_ROW: begin
          y <= y + YW'(1);
          x <= XW'(1);
        end
        S_NEXT_PASS: begin
          p <= p + PIX_W'(1);
          y <= YW'(1);
          x <= XW'(1);
        end
        S_DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_addr = rd_addr_c;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

`ifdef EDGE_DILATE_STATS_EN
  logic [ADDR_W-1:0] wr_count_q;

  always_ff @(posedge clk) begin
    if (reset)                         wr_count_q <= '0;
    else if (state == S_IDLE && bus.start) wr_count_q <= '0;
    else if (wr_en_q)                  wr_count_q <= wr_count_q + ADDR_W'(1);
  end

  assign bus.wr_count = wr_count_q;
`endif

endmodule
